// File: rtl/sid_i2s_pkg.sv
// sid_i2s_pkg: shared constants, types and the 16-bit saturator for the SID I2S transmitter.
package sid_i2s_pkg;
  localparam int SLOT_BITS = 16;
  localparam int FRAME_BITS = 32;
  localparam int LEFT_LAST_POS = 15;
  typedef logic signed [SLOT_BITS-1:0] sample_t;
  typedef logic [4:0] frame_pos_t;
  function automatic sample_t sat16(input logic signed [16:0] v);
    return v > 17'sd32767 ? 16'sh7FFF : v < -17'sd32768 ? 16'sh8000 : v[15:0];
  endfunction
endpackage

// File: rtl/sid_i2s_if.sv
// sid_i2s_if: sample input and I2S pin bundle between the SID audio path and the DAC.
interface sid_i2s_if;
  import sid_i2s_pkg::*;
  sample_t iIn;
  logic iMute;
  logic oBclk;
  logic oLrclk;
  logic oSdata;
  logic oSampleStrobe;
  modport master(output iIn, iMute, input oBclk, oLrclk, oSdata, oSampleStrobe);
  modport slave(input iIn, iMute, output oBclk, oLrclk, oSdata, oSampleStrobe);
endinterface

// File: rtl/sid_dc_block.sv
// sid_dc_block: leaky DC tracker; subtracts the tracked offset with saturation, updates on iEn.
module sid_dc_block import sid_i2s_pkg::*; #(
  parameter int DC_SHIFT = 10
) (
  input  logic    clk,
  input  logic    iRstN,
  input  logic    iEn,
  input  sample_t iX,
  output sample_t oY
);
  logic signed [31:0] dc_q, dc_d, err;
  always_comb begin
    err  = $signed({iX, 16'h0000}) - dc_q;
    dc_d = iEn ? dc_q + (err >>> DC_SHIFT) : dc_q;
    oY   = sat16({iX[15], iX} - {dc_q[31], dc_q[31:16]});
  end
  always_ff @(posedge clk or negedge iRstN)
    if (!iRstN) dc_q <= '0;
    else dc_q <= dc_d;
endmodule

// File: rtl/sid_i2s_tx.sv
// sid_i2s_tx: Philips I2S serialiser, mono sample on both slots, self-generated BCLK/LRCLK.
// Optional DC removal on the captured word when SID_I2S_DC_BLOCK_EN is defined.
module sid_i2s_tx import sid_i2s_pkg::*; #(
  parameter int CLK_DIV  = 8,
  parameter int DC_SHIFT = 10
) (
  input logic      clk,
  input logic      iRstN,
  sid_i2s_if.slave bus
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic bclk_q, bclk_d, lrclk_q, lrclk_d, sdata_q, sdata_d, strobe_q, strobe_d;
  frame_pos_t pos_q, pos_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic tc, fall, start;
  sample_t proc, word;
`ifdef SID_I2S_DC_BLOCK_EN
  sid_dc_block #(.DC_SHIFT(DC_SHIFT)) u_dc (
    .clk(clk), .iRstN(iRstN), .iEn(start), .iX(bus.iIn), .oY(proc)
  );
`else
  logic unused_dc_shift;
  assign unused_dc_shift = ^DC_SHIFT;
  assign proc = bus.iIn;
`endif
  always_comb begin
    tc        = div_cnt_q == DW'(CLK_DIV - 1);
    fall      = tc & bclk_q;
    start     = fall & (pos_q == frame_pos_t'(FRAME_BITS - 1));
    word      = bus.iMute ? '0 : proc;
    div_cnt_d = tc ? '0 : div_cnt_q + 1'b1;
    bclk_d    = tc ? ~bclk_q : bclk_q;
    pos_d     = fall ? pos_q + 5'd1 : pos_q;
    lrclk_d   = fall ? pos_d > frame_pos_t'(LEFT_LAST_POS) : lrclk_q;
    sdata_d   = fall ? shreg_q[FRAME_BITS-1] : sdata_q;
    shreg_d   = start ? {word, word} : fall ? shreg_q << 1 : shreg_q;
    strobe_d  = start;
  end
  always_ff @(posedge clk or negedge iRstN)
    if (!iRstN) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
      pos_q     <= frame_pos_t'(FRAME_BITS - 1);
      lrclk_q   <= 1'b1;
      sdata_q   <= 1'b0;
      strobe_q  <= 1'b0;
      shreg_q   <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
      pos_q     <= pos_d;
      lrclk_q   <= lrclk_d;
      sdata_q   <= sdata_d;
      strobe_q  <= strobe_d;
      shreg_q   <= shreg_d;
    end
  assign bus.oBclk         = bclk_q;
  assign bus.oLrclk        = lrclk_q;
  assign bus.oSdata        = sdata_q;
  assign bus.oSampleStrobe = strobe_q;
endmodule

// File: tb/tb_sid_i2s_tx.sv
// tb_sid_i2s_tx: frame-level checks of the I2S serialiser against a slot/bit-position reference model.
module tb_sid_i2s_tx;
  import sid_i2s_pkg::*;
  localparam int CLK_DIV = 2;
  logic clk = 1'b0;
  logic iRstN = 1'b0;
  always #5 clk = ~clk;
  sid_i2s_if bus();
  sid_i2s_tx #(.CLK_DIV(CLK_DIV), .DC_SHIFT(4)) dut (.clk(clk), .iRstN(iRstN), .bus(bus));
  int vectors = 0;
  int errors = 0;
  sample_t prev_word, last_word;
  logic prev_bclk, rise, strobe_seen;
  logic signed [31:0] dc;

  function automatic sample_t model_word(input sample_t x, input logic m);
    int y;
`ifdef SID_I2S_DC_BLOCK_EN
    y = int'(x) - int'(dc >>> 16);
    y = y > 32767 ? 32767 : y < -32768 ? -32768 : y;
    dc = dc + (((32'(int'(x)) <<< 16) - dc) >>> 4);
`else
    y = int'(x);
`endif
    return m ? sample_t'(0) : sample_t'(y);
  endfunction

  function automatic logic [31:0] exp_frame(input sample_t wp, input sample_t w);
    logic [31:0] e;
    e[0] = wp[0];
    for (int p = 1; p < 32; p++) e[p] = p <= 16 ? w[16-p] : w[32-p];
    return e;
  endfunction

  task automatic model_reset();
    prev_word = '0;
    last_word = '0;
    dc = '0;
    prev_bclk = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    strobe_seen = strobe_seen | bus.oSampleStrobe;
    if (bus.oSampleStrobe) begin
      prev_word = last_word;
      last_word = model_word(bus.iIn, bus.iMute);
    end
    rise = bus.oBclk & ~prev_bclk;
    prev_bclk = bus.oBclk;
  endtask

  task automatic wait_strobe();
    int n = 0;
    strobe_seen = 1'b0;
    while (!strobe_seen && n < 400) begin
      tick();
      n++;
    end
    if (!strobe_seen) begin
      vectors++;
      errors++;
      $display("FAIL strobe_timeout: no strobe within %0d clk, required one", n);
    end
  endtask

  task automatic collect(input int chg_rise, input sample_t chg_in, input logic chg_mute,
                         output logic [31:0] d, output logic [31:0] l);
    int n = 0;
    int guard = 0;
    d = '0;
    l = '0;
    while (n < 32 && guard < 600) begin
      tick();
      guard++;
      if (rise) begin
        d[n] = bus.oSdata;
        l[n] = bus.oLrclk;
        n++;
        if (n == chg_rise) begin
          bus.iIn = chg_in;
          bus.iMute = chg_mute;
        end
      end
    end
    if (n < 32) begin
      vectors++;
      errors++;
      $display("FAIL collect_timeout: got %0d bclk rises, required 32", n);
    end
  endtask

  task automatic test_reset();
    logic [3:0] bseq;
    logic [3:0] sseq;
    int n;
    bus.iIn = '0;
    bus.iMute = 1'b0;
    iRstN = 1'b0;
    model_reset();
    tick();
    tick();
    vectors++;
    if ({bus.oBclk, bus.oLrclk, bus.oSdata, bus.oSampleStrobe} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_values: bclk,lr,sd,st=%b required 0100",
               {bus.oBclk, bus.oLrclk, bus.oSdata, bus.oSampleStrobe});
    end
    iRstN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      bseq[k] = bus.oBclk;
      sseq[k] = bus.oSampleStrobe;
    end
    vectors++;
    if (bseq !== 4'b0110) begin
      errors++;
      $display("FAIL reset_bclk_seq: edges1..4 bclk=%b required 0110 (lsb=edge1)", bseq);
    end
    vectors++;
    if ({sseq, bus.oLrclk} !== 5'b10000) begin
      errors++;
      $display("FAIL first_strobe: strobe(lsb=edge1)=%b lr=%b required 1000 lr=0", sseq, bus.oLrclk);
    end
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.oSampleStrobe && n < 400);
    vectors++;
    if (n != 64 * CLK_DIV) begin
      errors++;
      $display("FAIL strobe_period: %0d clk required %0d", n, 64 * CLK_DIV);
    end
  endtask

  task automatic test_pattern();
    logic [31:0] d, l;
    bus.iIn = 16'sh8001;
    bus.iMute = 1'b0;
    wait_strobe();
    for (int f = 0; f < 2; f++) begin
      if (f) wait_strobe();
      collect(-1, '0, 1'b0, d, l);
      vectors++;
      if (d[16:1] !== 16'b1000000000000001 || d[31:17] !== 15'b000000000000001) begin
        errors++;
        $display("FAIL pattern_bits f%0d: got %b required left 1000000000000001 right(17..31 lsb first) 100000000000000", f, d);
      end
      vectors++;
      if (l !== 32'hFFFF0000) begin
        errors++;
        $display("FAIL pattern_lrclk f%0d: got %h required ffff0000", f, l);
      end
    end
    vectors++;
    if (d[0] !== 1'b1) begin
      errors++;
      $display("FAIL pattern_pos0: got %b required 1 (previous right lsb)", d[0]);
    end
  endtask

  task automatic test_hold();
    logic [31:0] d, l;
    sample_t wp;
    bus.iIn = 16'sh1234;
    wait_strobe();
    wp = prev_word;
    collect(1, 16'shFFFF, 1'b0, d, l);
    vectors++;
    if (d !== exp_frame(wp, 16'sh1234)) begin
      errors++;
      $display("FAIL hold_inflight: got %h required %h", d, exp_frame(wp, 16'sh1234));
    end
    wait_strobe();
    collect(-1, '0, 1'b0, d, l);
    vectors++;
    if (d !== exp_frame(16'sh1234, 16'shFFFF)) begin
      errors++;
      $display("FAIL hold_next: got %h required %h", d, exp_frame(16'sh1234, 16'shFFFF));
    end
  endtask

  task automatic test_mute();
    logic [31:0] d, l;
    bus.iIn = 16'sh7FFF;
    bus.iMute = 1'b0;
    wait_strobe();
    collect(8, 16'sh7FFF, 1'b1, d, l);
    vectors++;
    if (d[31:1] !== exp_frame(16'sh7FFF, 16'sh7FFF) >> 1) begin
      errors++;
      $display("FAIL mute_inflight: got %h required 7fff frame", d);
    end
    bus.iMute = 1'b0;
    wait_strobe();
    collect(8, 16'sh7FFF, 1'b1, d, l);
    vectors++;
    if (d !== exp_frame(16'sh7FFF, 16'sh7FFF)) begin
      errors++;
      $display("FAIL mute_released: got %h required %h", d, exp_frame(16'sh7FFF, 16'sh7FFF));
    end
    wait_strobe();
    collect(-1, '0, 1'b0, d, l);
    vectors++;
    if (d !== 32'h0000_0001) begin
      errors++;
      $display("FAIL mute_held: got %h required 00000001", d);
    end
    bus.iMute = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] d, l;
    sample_t w, wp;
    for (int f = 0; f < 8; f++) begin
      bus.iIn = sample_t'($urandom);
      bus.iMute = $urandom_range(3) == 0;
      wait_strobe();
      w = last_word;
      wp = prev_word;
      collect($urandom_range(1, 31), sample_t'($urandom), 1'($urandom_range(1)), d, l);
      vectors++;
      if (d !== exp_frame(wp, w)) begin
        errors++;
        $display("FAIL random_data f%0d: got %h required %h", f, d, exp_frame(wp, w));
      end
      vectors++;
      if (l !== 32'hFFFF0000) begin
        errors++;
        $display("FAIL random_lrclk f%0d: got %h required ffff0000", f, l);
      end
    end
    bus.iMute = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, l;
    int n;
    bus.iIn = 16'sh5AA5;
    wait_strobe();
    for (int k = 0; k < 20 * 2 * CLK_DIV + CLK_DIV; k++) tick();
    iRstN = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({bus.oBclk, bus.oLrclk, bus.oSdata, bus.oSampleStrobe} !== 4'b0100) begin
      errors++;
      $display("FAIL midreset_values: bclk,lr,sd,st=%b required 0100",
               {bus.oBclk, bus.oLrclk, bus.oSdata, bus.oSampleStrobe});
    end
    tick();
    tick();
    iRstN = 1'b1;
    n = 0;
    strobe_seen = 1'b0;
    while (!strobe_seen && n < 400) begin
      tick();
      n++;
    end
    vectors++;
    if (n != 2 * CLK_DIV) begin
      errors++;
      $display("FAIL midreset_first_strobe: %0d clk required %0d", n, 2 * CLK_DIV);
    end
    collect(-1, '0, 1'b0, d, l);
    vectors++;
    if (d !== exp_frame(16'sh0000, 16'sh5AA5)) begin
      errors++;
      $display("FAIL midreset_frame: got %h required %h", d, exp_frame(16'sh0000, 16'sh5AA5));
    end
  endtask

`ifdef SID_I2S_DC_BLOCK_EN
  task automatic test_dc();
    logic [31:0] d, l;
    sample_t w, wp;
    iRstN = 1'b0;
    model_reset();
    bus.iIn = 16'sd4096;
    bus.iMute = 1'b0;
    tick();
    iRstN = 1'b1;
    wait_strobe();
    collect(-1, '0, 1'b0, d, l);
    vectors++;
    if (d !== exp_frame(16'sh0000, 16'sd4096)) begin
      errors++;
      $display("FAIL dc_first: got %h required %h", d, exp_frame(16'sh0000, 16'sd4096));
    end
    wait_strobe();
    collect(-1, '0, 1'b0, d, l);
    vectors++;
    if (d !== exp_frame(16'sd4096, 16'sd3840)) begin
      errors++;
      $display("FAIL dc_second: got %h required %h", d, exp_frame(16'sd4096, 16'sd3840));
    end
    for (int f = 0; f < 3; f++) begin
      wait_strobe();
      w = last_word;
      wp = prev_word;
      collect(-1, '0, 1'b0, d, l);
      vectors++;
      if (d !== exp_frame(wp, w) || !(w < wp)) begin
        errors++;
        $display("FAIL dc_decay f%0d: got %h required %h (word %0d below %0d)", f, d, exp_frame(wp, w), w, wp);
      end
    end
    iRstN = 1'b0;
    model_reset();
    tick();
    iRstN = 1'b1;
    wait_strobe();
    bus.iIn = 16'sh8000;
    wait_strobe();
    collect(-1, '0, 1'b0, d, l);
    vectors++;
    if (d !== exp_frame(16'sd4096, 16'sh8000)) begin
      errors++;
      $display("FAIL dc_saturate: got %h required %h", d, exp_frame(16'sd4096, 16'sh8000));
    end
  endtask
`endif

  initial begin
    strobe_seen = 1'b0;
    rise = 1'b0;
    test_reset();
`ifdef SID_I2S_DC_BLOCK_EN
    test_dc();
    test_random();
    test_reset_mid();
`else
    test_pattern();
    test_hold();
    test_mute();
    test_random();
    test_reset_mid();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
